// File: rtl/lp_pkg.sv
// lp_pkg: shared state encoding and default parameters for the
// low-power sequencer (wfi_sleep_ctrl) and its synchronizers.
package lp_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DRAIN,
        ST_SLEEP,
        ST_RELOCK,
        ST_SETTLE
    } lp_state_e;

    localparam int LP_SYNC_STAGES   = 2;
    localparam int LP_N_WAKE        = 4;
    localparam int LP_SETTLE_CYCLES = 16;
    localparam int LP_TIMEOUT_W     = 24;

endpackage

// File: rtl/sync2.sv
// sync2: parameterized-width multi-flop synchronizer used for every
// asynchronous or core-clock input group entering the always-on domain.
module sync2
    import lp_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_q [LP_SYNC_STAGES];

    // Shift the raw input through the synchronizer chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LP_SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < LP_SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[LP_SYNC_STAGES-1];

endmodule

// File: rtl/wfi_sleep_ctrl.sv
// wfi_sleep_ctrl: WFI sleep/wake sequencer on the always-on clock.
// Optional WFI_TIMEOUT_EN compiles in the forced-wake sleep timeout.
module wfi_sleep_ctrl
    import lp_pkg::*;
#(
    parameter int N_WAKE        = LP_N_WAKE,
    parameter int SETTLE_CYCLES = LP_SETTLE_CYCLES,
    parameter int TIMEOUT_W     = LP_TIMEOUT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wfi_req,
    input  logic                 mem_busy,
    input  logic [N_WAKE-1:0]    wake_src,
    input  logic [N_WAKE-1:0]    wake_mask,
    input  logic [TIMEOUT_W-1:0] sleep_timeout,
    input  logic                 pll_lock,
    output logic                 wfi,
    output logic                 core_stall,
    output logic                 wake_done,
    output logic [N_WAKE:0]      wake_cause
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    logic              wfi_req_s;
    logic              mem_busy_s;
    logic              pll_lock_s;
    logic [N_WAKE-1:0] wake_src_s;
    logic [N_WAKE-1:0] wake_vec;
    logic              wake;
    logic              wfi_req_rise;
    logic              expire;
    logic              load_tmo;

    lp_state_e         state_q, state_d;
    logic              wfi_req_dly_q, wfi_req_dly_d;
    logic              mb_low_q, mb_low_d;
    logic [SW-1:0]     settle_cnt_q, settle_cnt_d;
    logic              wfi_q, wfi_d;
    logic              core_stall_q, core_stall_d;
    logic              wake_done_q, wake_done_d;
    logic [N_WAKE:0]   wake_cause_q, wake_cause_d;

    sync2 #(.W(3)) u_sync_ctl (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({wfi_req, mem_busy, pll_lock}),
        .q     ({wfi_req_s, mem_busy_s, pll_lock_s})
    );

    sync2 #(.W(N_WAKE)) u_sync_wake (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (wake_src),
        .q     (wake_src_s)
    );

    assign wake_vec     = wake_src_s & wake_mask;
    assign wake         = |wake_vec;
    assign wfi_req_rise = wfi_req_s & ~wfi_req_dly_q;

`ifdef WFI_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Timeout counter: loaded on SLEEP entry, counts down while asleep
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (load_tmo) begin
            tmo_cnt_d = sleep_timeout;
        end else if (state_q == ST_SLEEP && tmo_cnt_q != '0) begin
            tmo_cnt_d = tmo_cnt_q - TIMEOUT_W'(1);
        end
    end

    // Timeout counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign expire = (state_q == ST_SLEEP) && (sleep_timeout != '0)
                  && (tmo_cnt_q == TIMEOUT_W'(1));
`else
    logic unused_timeout;
    assign unused_timeout = ^{sleep_timeout, load_tmo};
    assign expire         = 1'b0;
`endif

    // Next-state and registered-output logic of the sleep sequencer
    always_comb begin
        state_d       = state_q;
        wfi_req_dly_d = wfi_req_s;
        mb_low_d      = mb_low_q;
        settle_cnt_d  = settle_cnt_q;
        wfi_d         = wfi_q;
        core_stall_d  = core_stall_q;
        wake_done_d   = 1'b0;
        wake_cause_d  = wake_cause_q;
        load_tmo      = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                wfi_d        = 1'b0;
                core_stall_d = 1'b0;
                if (wfi_req_rise) begin
                    state_d      = ST_DRAIN;
                    core_stall_d = 1'b1;
                    mb_low_d     = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (wake) begin
                    state_d      = ST_RUN;
                    core_stall_d = 1'b0;
                    wake_done_d  = 1'b1;
                    wake_cause_d = {1'b0, wake_vec};
                end else if (!mem_busy_s) begin
                    if (mb_low_q) begin
                        state_d  = ST_SLEEP;
                        wfi_d    = 1'b1;
                        load_tmo = 1'b1;
                    end else begin
                        mb_low_d = 1'b1;
                    end
                end else begin
                    mb_low_d = 1'b0;
                end
            end
            ST_SLEEP: begin
                if (wake || expire) begin
                    state_d      = ST_RELOCK;
                    wfi_d        = 1'b0;
                    wake_cause_d = {expire, wake_vec};
                end
            end
            ST_RELOCK: begin
                if (pll_lock_s) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d      = ST_RUN;
                    core_stall_d = 1'b0;
                    wake_done_d  = 1'b1;
                end else begin
                    settle_cnt_d = settle_cnt_q + SW'(1);
                end
            end
            default: begin
                state_d      = ST_RUN;
                wfi_d        = 1'b0;
                core_stall_d = 1'b0;
            end
        endcase
    end

    // Sequencer state and output registers; reset releases the core at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            wfi_req_dly_q <= 1'b0;
            mb_low_q      <= 1'b0;
            settle_cnt_q  <= '0;
            wfi_q         <= 1'b0;
            core_stall_q  <= 1'b0;
            wake_done_q   <= 1'b0;
            wake_cause_q  <= '0;
        end else begin
            state_q       <= state_d;
            wfi_req_dly_q <= wfi_req_dly_d;
            mb_low_q      <= mb_low_d;
            settle_cnt_q  <= settle_cnt_d;
            wfi_q         <= wfi_d;
            core_stall_q  <= core_stall_d;
            wake_done_q   <= wake_done_d;
            wake_cause_q  <= wake_cause_d;
        end
    end

    assign wfi        = wfi_q;
    assign core_stall = core_stall_q;
    assign wake_done  = wake_done_q;
    assign wake_cause = wake_cause_q;

endmodule

// File: tb/tb_wfi_sleep_ctrl.sv
// tb_wfi_sleep_ctrl: scenario-driven bench with a wake-cause scoreboard.
// Timeout scenarios adapt to WFI_TIMEOUT_EN.
module tb_wfi_sleep_ctrl;
    import lp_pkg::*;

    localparam int NW = 4;
    localparam int SC = 16;
    localparam int TW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wfi_req = 1'b0;
    logic          mem_busy = 1'b0;
    logic          pll_lock = 1'b0;
    logic [NW-1:0] wake_src = '0;
    logic [NW-1:0] wake_mask = '0;
    logic [TW-1:0] sleep_timeout = '0;
    logic          wfi;
    logic          core_stall;
    logic          wake_done;
    logic [NW:0]   wake_cause;

    int errors = 0;
    int checks = 0;
    logic [NW:0] exp_q[$];

    wfi_sleep_ctrl #(
        .N_WAKE(NW), .SETTLE_CYCLES(SC), .TIMEOUT_W(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wfi_req(wfi_req), .mem_busy(mem_busy),
        .wake_src(wake_src), .wake_mask(wake_mask),
        .sleep_timeout(sleep_timeout), .pll_lock(pll_lock),
        .wfi(wfi), .core_stall(core_stall), .wake_done(wake_done),
        .wake_cause(wake_cause)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, output int cyc,
                             output logic [NW:0] cause);
        cyc = -1;
        cause = '0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (wake_done) begin
                cyc = i;
                cause = wake_cause;
                break;
            end
        end
    endtask

    task automatic cleanup();
        wfi_req = 1'b0;
        wake_src = '0;
        pll_lock = 1'b0;
        sleep_timeout = '0;
        mem_busy = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wake_mask = 4'hF;
        #12;
        checks++;
        if (wfi !== 1'b0) begin
            errors++; $display("FAIL reset_wfi: got %b want 0", wfi);
        end
        checks++;
        if (core_stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b want 0", core_stall);
        end
        checks++;
        if (wake_done !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b want 0", wake_done);
        end
        checks++;
        if (wake_cause !== 5'b0) begin
            errors++; $display("FAIL reset_cause: got %b want 00000", wake_cause);
        end
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_basic();
        logic [NW:0] e;
        wake_mask = 4'hF;
        wfi_req = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if ({wfi, core_stall} !== {i >= 5, i >= 3}) begin
                errors++;
                $display("FAIL basic_entry t%0d: wfi/stall got %b%b want %b%b",
                         i, wfi, core_stall, i >= 5, i >= 3);
            end
        end
        repeat (5) tick();
        checks++;
        if (wfi !== 1'b1) begin
            errors++; $display("FAIL basic_sleep: wfi got %b want 1", wfi);
        end
        wake_src = 4'b0001;
        exp_q.push_back(5'b00001);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (wfi !== (i < 3)) begin
                errors++;
                $display("FAIL basic_wake t%0d: wfi got %b want %b", i, wfi, i < 3);
            end
        end
        repeat (2) tick();
        pll_lock = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            tick();
            checks++;
            if ({wake_done, core_stall} !== {i == 19, i != 19}) begin
                errors++;
                $display("FAIL basic_settle t%0d: done/stall got %b%b want %b%b",
                         i, wake_done, core_stall, i == 19, i != 19);
            end
            if (wake_done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL basic_cause: got %b want none", wake_cause);
                end else begin
                    e = exp_q.pop_front();
                    if (wake_cause !== e) begin
                        errors++; $display("FAIL basic_cause: got %b want %b", wake_cause, e);
                    end
                end
            end
        end
        tick();
        checks++;
        if (wake_done !== 1'b0) begin
            errors++; $display("FAIL basic_pulse: wake_done got %b want 0", wake_done);
        end
        cleanup();
    endtask

    task automatic test_drain_hold();
        int cyc;
        logic [NW:0] c, e;
        mem_busy = 1'b1;
        repeat (3) tick();
        wfi_req = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 10) mem_busy = 1'b0;
            checks++;
            if ({wfi, core_stall} !== {i >= 14, i >= 3}) begin
                errors++;
                $display("FAIL drain_hold t%0d: wfi/stall got %b%b want %b%b",
                         i, wfi, core_stall, i >= 14, i >= 3);
            end
        end
        wake_src = 4'b1000;
        pll_lock = 1'b1;
        exp_q.push_back(5'b01000);
        wait_done(60, cyc, c);
        checks++;
        if (cyc != 20) begin
            errors++; $display("FAIL drain_latency: got %0d want 20", cyc);
        end
        if (cyc > 0) begin
            checks++;
            e = exp_q.size() ? exp_q.pop_front() : 5'bx;
            if (c !== e) begin
                errors++; $display("FAIL drain_cause: got %b want %b", c, e);
            end
        end
        exp_q.delete();
        cleanup();
    endtask

    task automatic test_timeout();
        int cyc;
        logic [NW:0] c, e;
        wake_mask = 4'hF;
`ifdef WFI_TIMEOUT_EN
        sleep_timeout = 100;
        wfi_req = 1'b1;
        repeat (5) tick();
        for (int i = 1; i <= 100; i++) begin
            tick();
            checks++;
            if (wfi !== (i < 100)) begin
                errors++;
                $display("FAIL timeout_100 t%0d: wfi got %b want %b", i, wfi, i < 100);
            end
        end
        exp_q.push_back(5'b10000);
        pll_lock = 1'b1;
        wait_done(40, cyc, c);
        checks++;
        if (cyc != 19) begin
            errors++; $display("FAIL timeout_latency: got %0d want 19", cyc);
        end
        if (cyc > 0) begin
            checks++;
            e = exp_q.size() ? exp_q.pop_front() : 5'bx;
            if (c !== e) begin
                errors++; $display("FAIL timeout_cause: got %b want %b", c, e);
            end
        end
        exp_q.delete();
        cleanup();
        sleep_timeout = 1;
        wfi_req = 1'b1;
        repeat (5) tick();
        checks++;
        if (wfi !== 1'b1) begin
            errors++; $display("FAIL timeout_1_enter: wfi got %b want 1", wfi);
        end
        tick();
        checks++;
        if (wfi !== 1'b0) begin
            errors++; $display("FAIL timeout_1_exit: wfi got %b want 0", wfi);
        end
        pll_lock = 1'b1;
        exp_q.push_back(5'b10000);
`else
        sleep_timeout = 100;
        wfi_req = 1'b1;
        repeat (5) tick();
        for (int i = 1; i <= 150; i++) begin
            tick();
            checks++;
            if (wfi !== 1'b1) begin
                errors++; $display("FAIL timeout_off t%0d: wfi got %b want 1", i, wfi);
            end
        end
        wake_src = 4'b0001;
        pll_lock = 1'b1;
        exp_q.push_back(5'b00001);
`endif
        wait_done(60, cyc, c);
        checks++;
        e = exp_q.size() ? exp_q.pop_front() : 5'bx;
        if (cyc < 0 || c !== e) begin
            errors++; $display("FAIL timeout_end: cyc %0d cause %b want %b", cyc, c, e);
        end
        exp_q.delete();
        cleanup();
    endtask

    task automatic test_mask_early();
        int cyc;
        logic [NW:0] c, e;
        wake_mask = 4'b1011;
        wake_src = 4'b0100;
        repeat (3) tick();
        wfi_req = 1'b1;
        repeat (15) tick();
        checks++;
        if ({wfi, core_stall} !== 2'b11) begin
            errors++; $display("FAIL mask_block: wfi/stall got %b%b want 11", wfi, core_stall);
        end
        wake_src = 4'b0111;
        pll_lock = 1'b1;
        exp_q.push_back(5'b00011);
        wait_done(60, cyc, c);
        checks++;
        e = exp_q.size() ? exp_q.pop_front() : 5'bx;
        if (cyc < 0 || c !== e) begin
            errors++; $display("FAIL mask_cause: cyc %0d cause %b want %b", cyc, c, e);
        end
        exp_q.delete();
        wfi_req = 1'b0;
        pll_lock = 1'b0;
        wake_src = 4'b0010;
        repeat (4) tick();
        exp_q.push_back(5'b00010);
        wfi_req = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if ({wfi, core_stall, wake_done} !== {1'b0, i == 3, i == 4}) begin
                errors++;
                $display("FAIL early_wake t%0d: wfi/stall/done got %b%b%b want 0%b%b",
                         i, wfi, core_stall, wake_done, i == 3, i == 4);
            end
            if (wake_done) begin
                checks++;
                e = exp_q.size() ? exp_q.pop_front() : 5'bx;
                if (wake_cause !== e) begin
                    errors++; $display("FAIL early_cause: got %b want %b", wake_cause, e);
                end
            end
        end
        tick();
        checks++;
        if ({wfi, wake_done} !== 2'b00) begin
            errors++; $display("FAIL early_after: wfi/done got %b%b want 00", wfi, wake_done);
        end
        exp_q.delete();
        cleanup();
        wake_mask = 4'hF;
    endtask

    task automatic test_simultaneous();
`ifdef WFI_TIMEOUT_EN
        int cyc;
        int extra;
        logic [NW:0] c, e;
        wake_mask = 4'hF;
        sleep_timeout = 20;
        wfi_req = 1'b1;
        repeat (5) tick();
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 17) wake_src = 4'b0100;
            checks++;
            if (wfi !== (i < 20)) begin
                errors++;
                $display("FAIL simul_exit t%0d: wfi got %b want %b", i, wfi, i < 20);
            end
        end
        exp_q.push_back(5'b10100);
        pll_lock = 1'b1;
        wait_done(40, cyc, c);
        checks++;
        e = exp_q.size() ? exp_q.pop_front() : 5'bx;
        if (cyc < 0 || c !== e) begin
            errors++; $display("FAIL simul_cause: cyc %0d cause %b want %b", cyc, c, e);
        end
        extra = 0;
        repeat (25) begin
            tick();
            if (wake_done) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++; $display("FAIL simul_single: extra pulses %0d want 0", extra);
        end
        exp_q.delete();
        cleanup();
`endif
    endtask

    task automatic test_reset_sleep();
        wake_mask = 4'hF;
        wfi_req = 1'b1;
        repeat (5) tick();
        checks++;
        if ({wfi, core_stall} !== 2'b11 || wake_cause === 5'b0) begin
            errors++;
            $display("FAIL rst_pre: wfi/stall got %b%b cause %b want 11 nonzero",
                     wfi, core_stall, wake_cause);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wfi, core_stall, wake_done} !== 3'b000) begin
            errors++;
            $display("FAIL rst_async: wfi/stall/done got %b%b%b want 000",
                     wfi, core_stall, wake_done);
        end
        checks++;
        if (wake_cause !== 5'b0) begin
            errors++; $display("FAIL rst_cause: got %b want 00000", wake_cause);
        end
        wfi_req = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        checks++;
        if ({wfi, core_stall} !== 2'b00) begin
            errors++; $display("FAIL rst_after: wfi/stall got %b%b want 00", wfi, core_stall);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drain_hold();
        test_timeout();
        test_mask_early();
        test_simultaneous();
        test_reset_sleep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
